nc_context_ctrl: RTL and testbench
==================================

Name: nc_context_ctrl

Overview:
Sequences nC context derivation for CAVLC luma 4x4 blocks, one macroblock at a time.
- Keeps TotalCoeff history for the current MB (16 entries), the left neighbour column (4 entries) and a top line buffer (4 entries per MB column).
- For each block it selects nA/nB with availability, computes nC, and offers it to the coeff_token encoder over a valid/ready handshake.
- It then waits for that block's TotalCoeff before moving to the next block.

Parameters:
MB_COLS, 120, macroblocks per picture row (sets line-buffer depth MB_COLS*4)
MBX_W, 7, width of mb_x; must satisfy 2**MBX_W >= MB_COLS

Ports:
clk  in  1  clock, all state rising-edge
rst_n  in  1  asynchronous active-low reset
mb_start  in  1  start pulse for a new MB; sampled only in IDLE
mb_x  in  MBX_W  MB column of the MB being started
left_avail  in  1  left MB available (same slice), sampled with mb_start
top_avail  in  1  top MB available, sampled with mb_start
busy  out  1  high from accepted mb_start until mb_done
nc_valid  out  1  nc and blk_idx are valid
nc_ready  in  1  consumer accepts nc
nc  out  5  nC value, 0..16
blk_idx  out  4  luma 4x4 block index in decoding (zig-zag 8x8) order
tc_valid  in  1  TotalCoeff for blk_idx is presented
tc  in  5  TotalCoeff of current block, 0..16
mb_done  out  1  one-cycle pulse when the MB is complete

Behaviour:
- Reset values:
  - state=IDLE; busy, nc_valid, mb_done = 0; nc = 0; blk_idx = 0.
  - Current-MB array, left buffer and latched avail flags are cleared.
  - Line buffer is not reset; it is only read when top_avail = 1.
- Block coordinates: blkX = {idx[2], idx[0]}, blkY = {idx[3], idx[1]}.
- Neighbour A (left):
  - blkX > 0: cur[blkX-1, blkY].
  - blkX = 0: left_buf[blkY], available only if the latched left_avail = 1.
- Neighbour B (top):
  - blkY > 0: cur[blkX, blkY-1].
  - blkY = 0: line_buf[mb_x*4 + blkX], available only if the latched top_avail = 1.
- nC rule, computed at 6-bit width:
  - Both available: (nA + nB + 1) >> 1.
  - Only A: nA. Only B: nB. Neither: 0.
- FSM states: IDLE, ISSUE, WAIT_TC, WRBACK, DONE.
- IDLE:
  - On mb_start: latch mb_x, left_avail and top_avail; set blk_idx = 0; go to ISSUE.
  - nc_valid rises the next cycle, so latency is 1 cycle.
- ISSUE:
  - nc_valid = 1 with nc and blk_idx registered.
  - nc and blk_idx are held stable while nc_ready = 0.
  - Transfer when nc_valid & nc_ready; nc_valid drops the next cycle; go to WAIT_TC.
- WAIT_TC:
  - On tc_valid, write cur[blkX, blkY] = min(tc, 16).
  - If blkY = 3, also write line_buf[mb_x*4 + blkX].
  - If blk_idx = 15, go to WRBACK; otherwise increment blk_idx and go to ISSUE.
  - The next nc_valid is asserted the cycle after tc_valid.
  - The cur write is visible to the next block's neighbour selection, so there is no bypass hazard.
- tc_valid in any state other than WAIT_TC is ignored.
- WRBACK (1 cycle): left_buf[y] = cur[3, y] for y = 0..3.
- DONE: mb_done = 1 for one cycle; busy drops in the same cycle; return to IDLE.
- Bottom-row line-buffer writes occur after the same columns' top reads (blocks 10, 11, 14, 15 follow blocks 0, 1, 4, 5), so one buffer per column suffices.
- mb_start while busy is ignored.
- mb_x >= MB_COLS is clamped to MB_COLS-1.
- rst_n low mid-MB aborts immediately to reset values; no mb_done is produced.

Optional Feature:
NC_TABLE_SEL_EN:
- Present: adds output vlc_tab (2 bits), registered alongside nc and valid with nc_valid.
  - 0 for nC 0..1, 1 for 2..3, 2 for 4..7, 3 for >= 8.
  - Resets to 0.
- Absent: port and logic do not exist.

Decomposition:
- Package cavlc_nc_pkg holds:
  - constants TC_W = 5, BLK_IDX_W = 4, NC_MAX = 16;
  - the state enum typedef;
  - functions blk_x(idx) and blk_y(idx).
- One natural sub-module, nc_context_avg: combinational nA/nB/availability -> nC, implementing the rounded two-neighbour rule. The controller instantiates it.

Test Plan:
- No neighbours: left_avail = 0, top_avail = 0, every tc = 0 -> all 16 nc = 0; blk_idx sequence 0..15; mb_done one cycle after the WRBACK cycle following the 16th tc.
- Interior propagation: MB with tc = 4 for every block, no neighbours -> block 0 nc = 0, block 1 nc = 4 (A only), block 2 nc = 4 (B only), block 3 nc = 4 ((4+4+1)>>1).
- Rounding: left_buf from previous MB cols = 3; top line_buf = 2 at mb_x = 1; both avail -> block 0 nc = (3+2+1)>>1 = 3.
- Backpressure: hold nc_ready = 0 for 5 cycles -> nc and blk_idx stable and nc_valid held; tc_valid pulsed during ISSUE is ignored (cur unchanged).
- Saturation/line buffer: tc = 20 on block 15 at mb_x = 2 -> stored 16; next row same column with top_avail = 1, left_avail = 0 -> block 5 (blkX = 3, blkY = 0) nc = 16.
- Reset mid-MB: assert rst_n low in WAIT_TC of block 7 -> busy = 0, nc_valid = 0, no mb_done; a new mb_start restarts at blk_idx = 0.

Source files
------------

// File: rtl/cavlc_nc_pkg.sv
// Shared constants, FSM state type and block-coordinate helpers for CAVLC nC derivation.
package cavlc_nc_pkg;

  localparam int unsigned TC_W      = 5;
  localparam int unsigned BLK_IDX_W = 4;
  localparam int unsigned NC_MAX    = 16;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitTc,
    StWrback,
    StDone
  } state_e;

  // Luma 4x4 blocks are numbered in zig-zag 8x8 order; bits interleave x and y.
  function automatic logic [1:0] blk_x(input logic [BLK_IDX_W-1:0] idx);
    return {idx[2], idx[0]};
  endfunction

  function automatic logic [1:0] blk_y(input logic [BLK_IDX_W-1:0] idx);
    return {idx[3], idx[1]};
  endfunction

endpackage

// File: rtl/nc_context_avg.sv
// Combinational nC from neighbour TotalCoeffs: rounded mean of both, else whichever exists, else 0.
module nc_context_avg
  import cavlc_nc_pkg::*;
(
  input  logic [TC_W-1:0] na_i,
  input  logic [TC_W-1:0] nb_i,
  input  logic            a_avail_i,
  input  logic            b_avail_i,
  output logic [TC_W-1:0] nc_o
);

  logic [TC_W:0] sum;

  always_comb begin
    sum = {1'b0, na_i} + {1'b0, nb_i} + (TC_W+1)'(1);
    unique case ({a_avail_i, b_avail_i})
      2'b11:   nc_o = TC_W'(sum >> 1);
      2'b10:   nc_o = na_i;
      2'b01:   nc_o = nb_i;
      default: nc_o = '0;
    endcase
  end

endmodule

// File: rtl/nc_context_ctrl.sv
// Per-MB sequencer for CAVLC luma nC context: neighbour history, nC offer, TotalCoeff capture.
// Optional macro NC_TABLE_SEL_EN adds the registered vlc_tab output.
module nc_context_ctrl
  import cavlc_nc_pkg::*;
#(
  parameter int unsigned MB_COLS = 120,
  parameter int unsigned MBX_W   = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mb_start,
  input  logic [MBX_W-1:0]     mb_x,
  input  logic                 left_avail,
  input  logic                 top_avail,
  output logic                 busy,
  output logic                 nc_valid,
  input  logic                 nc_ready,
  output logic [TC_W-1:0]      nc,
  output logic [BLK_IDX_W-1:0] blk_idx,
  input  logic                 tc_valid,
  input  logic [TC_W-1:0]      tc,
  output logic                 mb_done
`ifdef NC_TABLE_SEL_EN
  ,
  output logic [1:0]           vlc_tab
`endif
);

  localparam int unsigned LbDepth = MB_COLS * 4;

  state_e               state_q, state_d;
  logic [BLK_IDX_W-1:0] blk_idx_q, blk_idx_d;
  logic [MBX_W-1:0]     mb_x_q, mb_x_d;
  logic                 left_avail_q, left_avail_d;
  logic                 top_avail_q, top_avail_d;
  logic [TC_W-1:0]      nc_q, nc_d;
  logic [TC_W-1:0]      cur_q [16];
  logic [TC_W-1:0]      cur_d [16];
  logic [TC_W-1:0]      left_q [4];
  logic [TC_W-1:0]      left_d [4];
  logic [TC_W-1:0]      line_buf_q [LbDepth];

  logic                 lb_we;
  logic [TC_W-1:0]      tc_sat;
  logic [1:0]           wr_x, wr_y, rd_x, rd_y;
  logic [TC_W-1:0]      na, nb, nc_calc;
  logic                 a_avail, b_avail;

  assign tc_sat = (tc > TC_W'(NC_MAX)) ? TC_W'(NC_MAX) : tc;
  assign wr_x   = blk_x(blk_idx_q);
  assign wr_y   = blk_y(blk_idx_q);

  always_comb begin
    state_d      = state_q;
    blk_idx_d    = blk_idx_q;
    mb_x_d       = mb_x_q;
    left_avail_d = left_avail_q;
    top_avail_d  = top_avail_q;
    cur_d        = cur_q;
    left_d       = left_q;
    lb_we        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mb_start) begin
          mb_x_d       = (32'(mb_x) >= MB_COLS) ? MBX_W'(MB_COLS - 1) : mb_x;
          left_avail_d = left_avail;
          top_avail_d  = top_avail;
          blk_idx_d    = '0;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (nc_ready) state_d = StWaitTc;
      end
      StWaitTc: begin
        if (tc_valid) begin
          cur_d[{wr_y, wr_x}] = tc_sat;
          lb_we = (wr_y == 2'd3);
          if (blk_idx_q == BLK_IDX_W'(15)) begin
            state_d = StWrback;
          end else begin
            blk_idx_d = blk_idx_q + BLK_IDX_W'(1);
            state_d   = StIssue;
          end
        end
      end
      StWrback: begin
        for (int y = 0; y < 4; y++) left_d[y] = cur_q[{2'(y), 2'd3}];
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Neighbours are taken from next-state values so the just-written TotalCoeff is seen.
  always_comb begin
    rd_x = blk_x(blk_idx_d);
    rd_y = blk_y(blk_idx_d);
    if (rd_x != 2'd0) begin
      na      = cur_d[{rd_y, rd_x - 2'd1}];
      a_avail = 1'b1;
    end else begin
      na      = left_q[rd_y];
      a_avail = left_avail_d;
    end
    if (rd_y != 2'd0) begin
      nb      = cur_d[{rd_y - 2'd1, rd_x}];
      b_avail = 1'b1;
    end else begin
      nb      = line_buf_q[{mb_x_d, rd_x}];
      b_avail = top_avail_d;
    end
  end

  nc_context_avg u_avg (
    .na_i      (na),
    .nb_i      (nb),
    .a_avail_i (a_avail),
    .b_avail_i (b_avail),
    .nc_o      (nc_calc)
  );

  always_comb begin
    nc_d = nc_q;
    if (state_d == StIssue) nc_d = nc_calc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      blk_idx_q    <= '0;
      mb_x_q       <= '0;
      left_avail_q <= 1'b0;
      top_avail_q  <= 1'b0;
      nc_q         <= '0;
      cur_q        <= '{default: '0};
      left_q       <= '{default: '0};
    end else begin
      state_q      <= state_d;
      blk_idx_q    <= blk_idx_d;
      mb_x_q       <= mb_x_d;
      left_avail_q <= left_avail_d;
      top_avail_q  <= top_avail_d;
      nc_q         <= nc_d;
      cur_q        <= cur_d;
      left_q       <= left_d;
    end
  end

  // Only read when top_avail is set, so no reset is needed.
  always_ff @(posedge clk) begin
    if (lb_we) line_buf_q[{mb_x_q, wr_x}] <= tc_sat;
  end

  assign busy     = (state_q == StIssue) || (state_q == StWaitTc) || (state_q == StWrback);
  assign nc_valid = (state_q == StIssue);
  assign mb_done  = (state_q == StDone);
  assign nc       = nc_q;
  assign blk_idx  = blk_idx_q;

`ifdef NC_TABLE_SEL_EN
  logic [1:0] vlc_tab_q, vlc_tab_d;

  always_comb begin
    vlc_tab_d = vlc_tab_q;
    if (state_d == StIssue) begin
      if (nc_calc < TC_W'(2))      vlc_tab_d = 2'd0;
      else if (nc_calc < TC_W'(4)) vlc_tab_d = 2'd1;
      else if (nc_calc < TC_W'(8)) vlc_tab_d = 2'd2;
      else                         vlc_tab_d = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vlc_tab_q <= 2'd0;
    else        vlc_tab_q <= vlc_tab_d;
  end

  assign vlc_tab = vlc_tab_q;
`endif

endmodule

// File: tb/tb_nc_context_ctrl.sv
// Randomised self-checking bench for nc_context_ctrl against a block-array reference model.
module tb_nc_context_ctrl;

  localparam int MbCols = 120;

  logic       clk, rst_n, mb_start, left_avail, top_avail;
  logic [6:0] mb_x;
  logic       busy, nc_valid, nc_ready, tc_valid, mb_done;
  logic [4:0] nc, tc;
  logic [3:0] blk_idx;

  nc_context_ctrl #(.MB_COLS(MbCols), .MBX_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mb_start   (mb_start),
    .mb_x       (mb_x),
    .left_avail (left_avail),
    .top_avail  (top_avail),
    .busy       (busy),
    .nc_valid   (nc_valid),
    .nc_ready   (nc_ready),
    .nc         (nc),
    .blk_idx    (blk_idx),
    .tc_valid   (tc_valid),
    .tc         (tc),
    .mb_done    (mb_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: TotalCoeff per (x,y) of current MB, left column, per-column bottom row.
  int cur_m  [16];
  int left_m [4];
  int line_m [MbCols*4];
  bit line_ok[MbCols];
  int tc_vec [16];
  int bp_force = -1;
  int first_nc, nc5;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_nc(input int idx, input int mbx, input bit la, input bit ta);
    int x, y, a, b;
    bit av_a, av_b;
    x = ((idx >> 2) & 1) * 2 + (idx & 1);
    y = ((idx >> 3) & 1) * 2 + ((idx >> 1) & 1);
    if (x > 0) begin a = cur_m[y*4 + x - 1]; av_a = 1; end
    else       begin a = left_m[y];          av_a = la; end
    if (y > 0) begin b = cur_m[(y-1)*4 + x]; av_b = 1; end
    else       begin b = line_m[mbx*4 + x];  av_b = ta; end
    if (av_a && av_b) return (a + b + 1) / 2;
    if (av_a) return a;
    if (av_b) return b;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) cur_m[i] = 0;
    for (int i = 0; i < 4; i++) left_m[i] = 0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++)
      tc_vec[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 31))
                                              : int'($urandom_range(0, 16));
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 16; i++) tc_vec[i] = v;
  endtask

  task automatic run_mb(input int mbx_in, input bit la, input bit ta, input int abort_blk);
    int mbx, e, bp, x, y, v;
    bit tav;
    mbx = (mbx_in >= MbCols) ? MbCols - 1 : mbx_in;
    tav = ta && line_ok[mbx];
    @(negedge clk);
    mb_start = 1'b1; mb_x = 7'(mbx_in); left_avail = la; top_avail = tav;
    @(negedge clk);
    mb_start = 1'b0; left_avail = $urandom_range(0, 1); top_avail = $urandom_range(0, 1);
    check_val("busy_up", busy, 1);
    for (int b = 0; b < 16; b++) begin
      e = exp_nc(b, mbx, la, tav);
      check_val("nc_valid_up", nc_valid, 1);
      check_val("blk_idx", blk_idx, b);
      check_val("nc", nc, e);
      if (b == 0) first_nc = nc;
      if (b == 5) nc5 = nc;
      bp = (bp_force >= 0) ? bp_force : int'($urandom_range(0, 3));
      for (int k = 0; k < bp; k++) begin
        if (k == 1) begin tc_valid = 1'b1; tc = 5'd9; end
        @(negedge clk);
        tc_valid = 1'b0;
        check_val("hold_valid", nc_valid, 1);
        check_val("hold_nc", nc, e);
        check_val("hold_idx", blk_idx, b);
      end
      nc_ready = 1'b1;
      @(negedge clk);
      nc_ready = 1'b0;
      check_val("nc_valid_drop", nc_valid, 0);
      if (b == abort_blk) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_valid", nc_valid, 0);
        check_val("rst_blk_idx", blk_idx, 0);
        check_val("rst_nc", nc, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check_val("rst_no_done", mb_done, 0);
        end
        return;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      tc_valid = 1'b1;
      tc = 5'(tc_vec[b]);
      v = (tc_vec[b] > 16) ? 16 : tc_vec[b];
      x = ((b >> 2) & 1) * 2 + (b & 1);
      y = ((b >> 3) & 1) * 2 + ((b >> 1) & 1);
      cur_m[y*4 + x] = v;
      if (y == 3) line_m[mbx*4 + x] = v;
      @(negedge clk);
      tc_valid = 1'b0;
    end
    check_val("wrback_no_done", mb_done, 0);
    check_val("wrback_busy", busy, 1);
    @(negedge clk);
    check_val("mb_done", mb_done, 1);
    check_val("done_busy", busy, 0);
    for (int i = 0; i < 4; i++) left_m[i] = cur_m[i*4 + 3];
    line_ok[mbx] = 1'b1;
    @(negedge clk);
    check_val("done_pulse", mb_done, 0);
  endtask

  initial begin
    rst_n = 1'b0; mb_start = 1'b0; mb_x = '0; left_avail = 1'b0; top_avail = 1'b0;
    nc_ready = 1'b0; tc_valid = 1'b0; tc = '0;
    model_reset();
    for (int i = 0; i < MbCols*4; i++) line_m[i] = 0;
    for (int i = 0; i < MbCols; i++) line_ok[i] = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_busy", busy, 0);
    check_val("reset_valid", nc_valid, 0);
    check_val("reset_done", mb_done, 0);
    check_val("reset_nc", nc, 0);
    check_val("reset_blk_idx", blk_idx, 0);
    rst_n = 1'b1;

    // No neighbours, all zero
    fill_const(0);
    run_mb(0, 0, 0, -1);
    // Interior propagation
    fill_const(4);
    run_mb(0, 0, 0, -1);
    // Rounding across left and top neighbours
    fill_const(2);
    run_mb(1, 0, 0, -1);
    fill_const(3);
    run_mb(0, 0, 0, -1);
    fill_const(0);
    run_mb(1, 1, 1, -1);
    check_val("round_blk0", first_nc, 3);
    // Long backpressure with ignored tc_valid pulses
    bp_force = 5;
    fill_rand();
    run_mb(3, 1, 0, -1);
    bp_force = -1;
    // Saturation into line buffer, then read from the next row
    fill_const(0);
    tc_vec[15] = 20;
    run_mb(2, 0, 0, -1);
    fill_const(0);
    tc_vec[4] = 16;
    run_mb(2, 0, 1, -1);
    check_val("sat_blk5", nc5, 16);
    // Reset in WAIT_TC of block 7, then a clean restart
    fill_rand();
    run_mb(4, 1, 0, 7);
    fill_rand();
    run_mb(4, 0, 0, -1);
    // Random MBs, including out-of-range mb_x
    for (int n = 0; n < 20; n++) begin
      int mx;
      fill_rand();
      case ($urandom_range(0, 7))
        6:       mx = 119;
        7:       mx = 127;
        default: mx = int'($urandom_range(0, 5));
      endcase
      run_mb(mx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
